multicycle_controller: RTL

- Sequencing FSM for the multicycle RV32I datapath, which uses a shared instruction/data memory, one ALU and the IR/OldPC/ALUOut/Data registers.
- Decodes the opcode held in the IR and steps each instruction through 3-5 states.
- Drives all datapath selects and write strobes, and embeds the ALU function decode.
- Supports lw, sw, R-type, I-type ALU, jal and beq; every other opcode is treated as illegal.

---
 rtl/multicycle_controller.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Sequencing FSM for a multicycle RV32I datapath: shared instruction/data
// memory, one ALU, and IR/OldPC/ALUOut/Data registers. It decodes the opcode
// held in the IR and steps each instruction through 3-5 states. It drives every
// datapath select and write strobe, and it contains the ALU function decode.
// Supported instructions: lw, sw, R-type, I-type ALU, jal and beq. Any other
// opcode returns to FETCH after DECODE and has no architectural effect.
//
// Optional feature: define BNE_EN to add bne. A taken branch then needs
// Zero=0 when funct3[0]=1. Without BNE_EN, bne behaves like beq.
//
// Ports:
//   clk, rst_n   core clock (rising edge) and asynchronous active-low reset
//   op           IR[6:0]
//   funct3       IR[14:12]
//   funct7b5     IR[30]
//   Zero         ALU zero flag
//   PCWrite      PC register enable
//   AdrSrc       memory address select (0=PC, 1=ALUOut/Result)
//   MemWrite     memory write strobe
//   IRWrite      IR and OldPC load enable
//   ResultSrc    result select (00=ALUOut, 01=Data, 10=ALUResult)
//   ALUSrcA      ALU operand A (00=PC, 01=OldPC, 10=rd1)
//   ALUSrcB      ALU operand B (00=rd2, 01=ImmExt, 10=constant 4)
//   RegWrite     register file write enable
//   ImmSrc       immediate format (00=I, 01=S, 10=B, 11=J)
//   ALUControl   ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   state        current FSM state, for debug
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECR    = STATE_W'(6),
    ALUWB    = STATE_W'(7),
    EXECI    = STATE_W'(8),
    JAL      = STATE_W'(9),
    BEQ      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     state_q, state_d;
  logic       pc_update, branch, branch_taken;
  logic       ir_write, mem_write, reg_write;
  logic [1:0] alu_op;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value and simulation matches the synthesized hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // NOTE: each signal gets a default before the case statement. Any state that
  // does not assign a signal then keeps the default, so no latch is inferred.
  always_comb begin
    state_d   = FETCH;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    alu_op    = 2'b00;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_update = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        // The ALU computes OldPC + imm here, ahead of a possible branch or jump.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: reg_write = 1'b1;
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = ALUWB;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

`ifdef BNE_EN
  assign branch_taken = branch & (Zero ^ funct3[0]);
`else
  assign branch_taken = branch & Zero;
`endif

  // The reset register already selects the FETCH state. FETCH itself raises
  // IRWrite and PCWrite, so all strobes are also gated by rst_n. This keeps the
  // datapath inactive while reset is held.
  assign PCWrite  = rst_n & (pc_update | branch_taken);
  assign IRWrite  = rst_n & ir_write;
  assign MemWrite = rst_n & mem_write;
  assign RegWrite = rst_n & reg_write;

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          // op[5] separates R-type from I-type, because addi has no subtract.
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  assign state = state_q;

endmodule
